// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and bus widths for the AHB-to-APB bridge.
package ahb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    BU_SINGLE = 3'b000,
    BU_INCR   = 3'b001,
    BU_WRAP4  = 3'b010,
    BU_INCR4  = 3'b011,
    BU_WRAP8  = 3'b100,
    BU_INCR8  = 3'b101,
    BU_WRAP16 = 3'b110,
    BU_INCR16 = 3'b111
  } hburst_t;

endpackage

// File: rtl/ahb_slave.sv
// AHB-Lite slave front end: qualifies transfers into VALID and pipelines the
// address phase (address, direction) and the following write data phase.
module ahb_slave
  import ahb_pkg::*;
(
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HBURST,
  input  logic [1:0]        HTRANS,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [ADDR_W-1:0] HADDR_TEMP,
  output logic [DATA_W-1:0] HWDATA_TEMP,
  output logic              VALID,
  output logic              HWRITE_TEMP
);

  logic              xfer_s;
  logic              valid_s;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic              hwrite_q, hwrite_d;
  logic              wr_pend_q, wr_pend_d;
  logic              unused_s;

  // Burst type never alters addressing; addresses are taken exactly as driven.
  assign unused_s = ^{HBURST, 1'b0};

  assign xfer_s  = (HTRANS == TR_NONSEQ) || (HTRANS == TR_SEQ);
  assign valid_s = HRESETn & HSEL & HREADY & xfer_s;

  // Next-state for the address-phase and data-phase pipeline registers.
  always_comb begin
    haddr_d   = haddr_q;
    hwrite_d  = hwrite_q;
    hwdata_d  = hwdata_q;
    wr_pend_d = wr_pend_q;
    if (valid_s) begin
      haddr_d  = HADDR;
      hwrite_d = HWRITE;
    end else begin
      haddr_d  = haddr_q;
      hwrite_d = hwrite_q;
    end
    // Data phase of a write completes on the edge where HREADY is high.
    if (HREADY) begin
      wr_pend_d = valid_s & HWRITE;
      hwdata_d  = wr_pend_q ? HWDATA : hwdata_q;
    end else begin
      wr_pend_d = wr_pend_q;
      hwdata_d  = hwdata_q;
    end
  end

  // Pipeline register bank; reset discards any pending write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_q   <= {ADDR_W{1'b0}};
      hwrite_q  <= 1'b0;
      hwdata_q  <= {DATA_W{1'b0}};
      wr_pend_q <= 1'b0;
    end else begin
      haddr_q   <= haddr_d;
      hwrite_q  <= hwrite_d;
      hwdata_q  <= hwdata_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  assign VALID       = valid_s;
  assign HADDR_TEMP  = haddr_q;
  assign HWRITE_TEMP = hwrite_q;
  assign HWDATA_TEMP = hwdata_q;

endmodule

// File: tb/tb_ahb_slave.sv
// Directed self-checking bench for ahb_slave.
module tb_ahb_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HBURST;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HADDR_TEMP;
  logic [31:0] HWDATA_TEMP;
  logic        VALID;
  logic        HWRITE_TEMP;

  int checks = 0;
  int errors = 0;

  ahb_slave dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HWRITE(HWRITE), .HBURST(HBURST), .HTRANS(HTRANS), .HREADY(HREADY),
    .HWDATA(HWDATA), .HADDR_TEMP(HADDR_TEMP), .HWDATA_TEMP(HWDATA_TEMP),
    .VALID(VALID), .HWRITE_TEMP(HWRITE_TEMP)
  );

  always #5 HCLK = ~HCLK;

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; HSEL = 1'b1; HADDR = 32'h0000_0ABC; HWRITE = 1'b1;
    HBURST = 3'b000; HTRANS = 2'b10; HREADY = 1'b1; HWDATA = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", VALID); end
    cyc(); cyc();
    checks++;
    if ({HADDR_TEMP, HWDATA_TEMP, HWRITE_TEMP} !== 65'd0) begin
      errors++;
      $display("FAIL reset_regs: got addr=%h data=%h wr=%b want all 0", HADDR_TEMP, HWDATA_TEMP, HWRITE_TEMP);
    end
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    #2 HRESETn = 1'b1;
    #1;
    checks++;
    if (VALID !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", VALID); end
    cyc(); cyc();
    checks++;
    if ({HADDR_TEMP, HWDATA_TEMP, HWRITE_TEMP} !== 65'd0) begin
      errors++;
      $display("FAIL idle_regs: got addr=%h data=%h wr=%b want all 0", HADDR_TEMP, HWDATA_TEMP, HWRITE_TEMP);
    end
  endtask

  task automatic test_single_write();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4; HBURST = 3'b000; HREADY = 1'b1;
    #1;
    checks++;
    if (VALID !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", VALID); end
    cyc();
    checks++;
    if (HADDR_TEMP !== 32'h4 || HWRITE_TEMP !== 1'b1) begin
      errors++; $display("FAIL single_addr: got addr=%h wr=%b want 00000004/1", HADDR_TEMP, HWRITE_TEMP);
    end
    checks++;
    if (HWDATA_TEMP !== 32'h0) begin errors++; $display("FAIL single_data_early: got %h want 00000000", HWDATA_TEMP); end
    HTRANS = 2'b00; HWDATA = 32'h1111_1111;
    cyc();
    checks++;
    if (HWDATA_TEMP !== 32'h1111_1111) begin errors++; $display("FAIL single_data: got %h want 11111111", HWDATA_TEMP); end
  endtask

  task automatic test_back_to_back_writes();
    logic [31:0] d;
    HSEL = 1'b1; HWRITE = 1'b1; HREADY = 1'b1; HBURST = 3'b001;
    for (int i = 0; i < 16; i++) begin
      HTRANS = (i == 0) ? 2'b10 : 2'b11;
      HADDR  = 32'(4 * (i + 1));
      HWDATA = 32'h1111_1111 * 32'(i);
      #1;
      checks++;
      if (VALID !== 1'b1) begin errors++; $display("FAIL b2b_wr_valid[%0d]: got %b want 1", i, VALID); end
      cyc();
      checks++;
      if (HADDR_TEMP !== 32'(4 * (i + 1)) || HWRITE_TEMP !== 1'b1) begin
        errors++; $display("FAIL b2b_wr_addr[%0d]: got %h/%b want %h/1", i, HADDR_TEMP, HWRITE_TEMP, 32'(4 * (i + 1)));
      end
      if (i > 0) begin
        d = 32'h1111_1111 * 32'(i);
        checks++;
        if (HWDATA_TEMP !== d) begin errors++; $display("FAIL b2b_wr_data[%0d]: got %h want %h", i, HWDATA_TEMP, d); end
      end
    end
  endtask

  task automatic test_back_to_back_reads();
    HWRITE = 1'b0; HTRANS = 2'b10;
    for (int i = 0; i < 16; i++) begin
      HADDR  = 32'h3C - 32'(4 * i);
      HWDATA = (i == 0) ? 32'h1111_1110 : 32'hDEAD_BEEF;
      if (i > 0) HTRANS = 2'b11;
      #1;
      checks++;
      if (VALID !== 1'b1) begin errors++; $display("FAIL b2b_rd_valid[%0d]: got %b want 1", i, VALID); end
      cyc();
      checks++;
      if (HADDR_TEMP !== 32'h3C - 32'(4 * i) || HWRITE_TEMP !== 1'b0) begin
        errors++; $display("FAIL b2b_rd_addr[%0d]: got %h/%b want %h/0", i, HADDR_TEMP, HWRITE_TEMP, 32'h3C - 32'(4 * i));
      end
      checks++;
      if (HWDATA_TEMP !== 32'h1111_1110) begin
        errors++; $display("FAIL b2b_rd_data[%0d]: got %h want 11111110", i, HWDATA_TEMP);
      end
    end
    HTRANS = 2'b00;
    cyc();
  endtask

  task automatic test_qualification();
    HADDR = 32'h100; HWRITE = 1'b1; HWDATA = 32'h7777_7777;
    for (int k = 0; k < 3; k++) begin
      HSEL   = (k == 1) ? 1'b0 : 1'b1;
      HTRANS = (k == 0) ? 2'b01 : 2'b10;
      HREADY = (k == 2) ? 1'b0 : 1'b1;
      #1;
      checks++;
      if (VALID !== 1'b0) begin errors++; $display("FAIL qual_valid[%0d]: got %b want 0", k, VALID); end
      cyc();
      checks++;
      if (HADDR_TEMP !== 32'h0 || HWRITE_TEMP !== 1'b0 || HWDATA_TEMP !== 32'h1111_1110) begin
        errors++; $display("FAIL qual_hold[%0d]: got %h/%b/%h want 00000000/0/11111110", k, HADDR_TEMP, HWRITE_TEMP, HWDATA_TEMP);
      end
    end
    HSEL = 1'b1; HTRANS = 2'b10; HREADY = 1'b1; HADDR = 32'h200;
    cyc();
    HTRANS = 2'b00; HREADY = 1'b0; HWDATA = 32'hA5A5_A5A5;
    cyc();
    checks++;
    if (HWDATA_TEMP !== 32'h1111_1110 || HADDR_TEMP !== 32'h200) begin
      errors++; $display("FAIL wait_hold: got %h/%h want 11111110/00000200", HWDATA_TEMP, HADDR_TEMP);
    end
    cyc();
    checks++;
    if (HWDATA_TEMP !== 32'h1111_1110) begin errors++; $display("FAIL wait_hold2: got %h want 11111110", HWDATA_TEMP); end
    HREADY = 1'b1; HWDATA = 32'h5A5A_5A5A;
    cyc();
    checks++;
    if (HWDATA_TEMP !== 32'h5A5A_5A5A) begin errors++; $display("FAIL wait_capture: got %h want 5a5a5a5a", HWDATA_TEMP); end
  endtask

  task automatic test_async_reset();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HREADY = 1'b1; HADDR = 32'h300;
    cyc();
    HTRANS = 2'b00; HWDATA = 32'hCAFE_F00D;
    #1 HRESETn = 1'b0;
    #1;
    checks++;
    if ({HADDR_TEMP, HWDATA_TEMP, HWRITE_TEMP, VALID} !== 66'd0) begin
      errors++;
      $display("FAIL async_reset: got %h/%h/%b/%b want all 0", HADDR_TEMP, HWDATA_TEMP, HWRITE_TEMP, VALID);
    end
    cyc();
    #2 HRESETn = 1'b1;
    cyc();
    checks++;
    if (HWDATA_TEMP !== 32'h0 || HADDR_TEMP !== 32'h0) begin
      errors++; $display("FAIL post_reset_data: got %h/%h want 00000000/00000000", HWDATA_TEMP, HADDR_TEMP);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back_writes();
    test_back_to_back_reads();
    test_qualification();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave.md
# ahb_slave

AHB-Lite slave front end of the AHB-to-APB bridge. It qualifies AHB transfers into a single VALID strobe and pipelines each valid transfer's address, direction and write data into registered outputs. The bridge controller FSM consumes these outputs and drives the APB side. This block never stalls the bus and generates no HREADYOUT or HRESP.

## Interface
- Parameters: none; all widths are fixed at 32-bit address and 32-bit data.
- HCLK  in  1  bus clock; all registers update on its rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the AHB decoder.
- HADDR  in  32  address-phase address.
- HWRITE  in  1  address-phase direction: 1 = write, 0 = read.
- HBURST  in  3  burst type; accepted but functionally ignored.
- HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HREADY  in  1  bus-wide ready; 1 = current phase completes this cycle.
- HWDATA  in  32  write data, valid in the data phase.
- HADDR_TEMP  out  32  registered address of the last valid transfer.
- HWDATA_TEMP  out  32  registered write data of the last valid write.
- VALID  out  1  combinational transfer-qualified strobe.
- HWRITE_TEMP  out  1  registered direction of the last valid transfer.

## Operation
- VALID = HRESETn & HSEL & HREADY & HTRANS[1].
  - True only for NONSEQ or SEQ.
  - IDLE, BUSY, deselect, HREADY=0 or reset active all force VALID=0.
- On a rising edge with VALID=1:
  - HADDR_TEMP <= HADDR
  - HWRITE_TEMP <= HWRITE
- When VALID=0, HADDR_TEMP and HWRITE_TEMP hold their values.
- Internal flag wr_pend captures VALID & HWRITE on every edge where HREADY=1. It holds while HREADY=0.
- On a rising edge with wr_pend=1 and HREADY=1, HWDATA_TEMP <= HWDATA. This captures the data phase of the prior write.
- Read transfers never modify HWDATA_TEMP.
- HBURST does not affect address capture; addresses are taken exactly as driven, with no internal incrementing or wrapping.
- Back-to-back transfers are supported with no idle cycles. The address of transfer N+1 and the data of transfer N are captured on the same edge.
- Write followed by read: the read's address is captured, and the pending write's HWDATA is captured on the same edge.

## Timing
- Reset (HRESETn=0, asynchronous): HADDR_TEMP=0, HWDATA_TEMP=0, HWRITE_TEMP=0, wr_pend=0, VALID=0 immediately.
- Reset release: first capture is possible on the first rising edge with HRESETn=1.
- VALID: 0-cycle latency, combinational from inputs.
- HADDR_TEMP / HWRITE_TEMP: visible 1 cycle after the address phase (after the edge that ends it).
- HWDATA_TEMP: visible 1 cycle after the data phase, i.e. 2 edges after the write address phase when HREADY stays 1.
- HREADY=0 wait states: every register, including wr_pend, holds.
- Reset mid-transfer: the pending write is discarded; no data capture follows.

## Structure
- Shared package `ahb_pkg`:
  - HTRANS encodings: IDLE, BUSY, NONSEQ, SEQ.
  - HBURST encodings: SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16.
  - Constants ADDR_W=32 and DATA_W=32.
- Single flat module; no sub-module is needed.
- Valid decode and pipeline registers live in one file.

## Test plan
- Reset and idle:
  - Drive HRESETn=0 -> all outputs read 0.
  - Release reset with HSEL=0, HTRANS=00, HREADY=1 -> VALID=0 and all registers stay 0.
- Single write:
  - Drive HSEL=1, HTRANS=10, HWRITE=1, HADDR=0x4, HBURST=000, HREADY=1 -> VALID=1 in the same cycle.
  - Next cycle -> HADDR_TEMP=0x4, HWRITE_TEMP=1.
  - Drive HWDATA=0x11111111 in the data phase -> HWDATA_TEMP=0x11111111 one cycle later.
- Sixteen back-to-back writes:
  - Addresses 0x4, 0x8, … 0x40; data 0x11111111, 0x22222222, … (increment 0x11111111, 32-bit wrap).
  - Required: VALID stays 1 throughout, and each address and data value appears in order with the stated latencies.
- Sixteen back-to-back reads:
  - Addresses 0x3C down to 0x0 with HWRITE=0.
  - Required: HWRITE_TEMP=0 one cycle after the first read, HADDR_TEMP tracks each address, and HWDATA_TEMP changes only for the final write's data phase.
- Qualification:
  - HTRANS=01 (BUSY), or HSEL=0, or HREADY=0 with HTRANS=10 -> VALID=0 and registers hold.
  - A wait state inserted after a write address phase -> HWDATA_TEMP is captured only on the edge where HREADY returns to 1.
- Asynchronous reset mid-burst:
  - Assert HRESETn=0 between clock edges during writes -> outputs are 0 immediately, without waiting for an edge.
  - After release, the prior pending write data is not captured.
